// File: rtl/reflex_round_scheduler.sv
// Reflex-trainer round sequencer: 1 ms tick, LFSR arm delay, reaction timing.
// Ports: clk, rst_n (sync, active-low), start, btn in; stim, busy, done,
//   foul, timeout, react_ms, best_ms, state out. Optional: BEST_TIME_EN.
module reflex_round_scheduler #(
  parameter int CLK_HZ           = 100_000_000,
  parameter int TICK_HZ          = 1000,
  parameter int MIN_DELAY_MS     = 1000,
  parameter int DELAY_RANGE_BITS = 11,
  parameter int TIMEOUT_MS       = 2000,
  parameter int REACT_W          = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               btn,
  output logic               stim,
  output logic               busy,
  output logic               done,
  output logic               foul,
  output logic               timeout,
  output logic [REACT_W-1:0] react_ms,
  output logic [REACT_W-1:0] best_ms,
  output logic [2:0]         state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam int DLY_MAX  = MIN_DELAY_MS + (1 << DELAY_RANGE_BITS) - 1;
  localparam int DLY_W    = $clog2(DLY_MAX + 1);

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DLY_W-1:0]   DLY_MIN  = DLY_W'(MIN_DELAY_MS);
  localparam logic [REACT_W-1:0] TMO      = REACT_W'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STIM   = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [REACT_W-1:0] rcnt_q, rcnt_d;
  logic [REACT_W-1:0] react_q, react_d;
  logic               stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               foul_q, foul_d;
  logic               tmo_q, tmo_d;
  logic               tick;
  logic               fb;
  logic [REACT_W-1:0] rcnt_inc;

  always_comb begin
    fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = {fb, lfsr_q[15:1]};
    tick     = (pre_q == PRE_LAST);
    rcnt_inc = rcnt_q + REACT_W'(1);
    state_d  = state_q;
    dly_d    = dly_q;
    rcnt_d   = rcnt_q;
    react_d  = react_q;
    done_d   = 1'b0;
    foul_d   = foul_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_ARM: begin
        if (btn) begin
          state_d = S_FOUL;
          foul_d  = 1'b1;
          done_d  = 1'b1;
          react_d = '0;
        end else if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            state_d = S_STIM;
            rcnt_d  = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      S_STIM: begin
        if (btn) begin
          // a press on a tick edge includes that tick
          state_d = S_RESULT;
          done_d  = 1'b1;
          react_d = tick ? rcnt_inc : rcnt_q;
        end else if (tick) begin
          rcnt_d = rcnt_inc;
          if (rcnt_inc == TMO) begin
            state_d = S_RESULT;
            tmo_d   = 1'b1;
            react_d = TMO;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_ARM;
          dly_d   = DLY_MIN + DLY_W'(lfsr_q[DELAY_RANGE_BITS-1:0]);
          foul_d  = 1'b0;
          tmo_d   = 1'b0;
          react_d = '0;
        end
      end
    endcase
    // restart the tick phase on every state entry
    if (state_d != state_q || tick) pre_d = '0;
    else                            pre_d = pre_q + PRE_W'(1);
    stim_d = (state_d == S_STIM);
    busy_d = (state_d == S_ARM) || (state_d == S_STIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      lfsr_q  <= 16'hACE1;
      dly_q   <= '0;
      rcnt_q  <= '0;
      react_q <= '0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      foul_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      dly_q   <= dly_d;
      rcnt_q  <= rcnt_d;
      react_q <= react_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      foul_q  <= foul_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef BEST_TIME_EN
  logic [REACT_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (state_q == S_STIM && btn && react_d < best_q)
      best_d = react_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) best_q <= '1;
    else        best_q <= best_d;
  end

  assign best_ms = best_q;
`else
  assign best_ms = '1;
`endif

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign foul     = foul_q;
  assign timeout  = tmo_q;
  assign react_ms = react_q;
  assign state    = state_q;

endmodule

// File: tb/tb_reflex_round_scheduler.sv
// Bench for reflex_round_scheduler: directed round table plus random
// stimulus checked every cycle against a timestamp-based reference model.
module tb_reflex_round_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic        stim, busy, done, foul, timeout;
  logic [11:0] react_ms, best_ms;
  logic [2:0]  state;

  reflex_round_scheduler #(
    .CLK_HZ(1000), .TICK_HZ(100), .MIN_DELAY_MS(4),
    .DELAY_RANGE_BITS(2), .TIMEOUT_MS(20), .REACT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
    .stim(stim), .busy(busy), .done(done), .foul(foul),
    .timeout(timeout), .react_ms(react_ms), .best_ms(best_ms),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: state plus edge timestamps
  int cyc = 0;
  int m_state = 0;
  int m_t0 = 0;
  int m_D = 0;
  int m_react = 0;
  int m_best = 4095;
  int m_lfsr = 16'hACE1;
  bit m_foul = 0;
  bit m_tmo = 0;
  bit m_done = 0;

  typedef struct {
    int    kind;
    int    off;
    bit    bstart;
    int    react;
    bit    foul;
    bit    tmo;
    int    st;
    int    best;
    string name;
  } vec_t;

  vec_t tv[7];

  function automatic int lfsr_next(input int x);
    int f;
    f = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return ((x >> 1) | (f << 15)) & 16'hFFFF;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int el;
    cyc++;
    if (!rst_n) begin
      m_state = 0; m_foul = 0; m_tmo = 0; m_done = 0;
      m_react = 0; m_best = 4095; m_lfsr = 16'hACE1;
      return;
    end
    m_done = 0;
    el = cyc - m_t0;
    case (m_state)
      1: begin
        if (btn) begin
          m_state = 4; m_foul = 1; m_done = 1; m_react = 0;
        end else if (el == 10 * m_D) begin
          m_state = 2; m_t0 = cyc;
        end
      end
      2: begin
        if (btn) begin
          m_state = 3; m_react = el / 10; m_done = 1;
`ifdef BEST_TIME_EN
          if (m_react < m_best) m_best = m_react;
`endif
        end else if (el == 200) begin
          m_state = 3; m_tmo = 1; m_react = 20; m_done = 1;
        end
      end
      default: begin
        if (start) begin
          m_state = 1; m_D = 4 + (m_lfsr & 3); m_t0 = cyc;
          m_foul = 0; m_tmo = 0; m_react = 0;
        end
      end
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic model_check();
    logic [31:0] a, e;
    a = {stim, busy, done, foul, timeout, react_ms, best_ms, state};
    e = {m_state == 2, m_state == 1 || m_state == 2, m_done, m_foul,
         m_tmo, 12'(m_react), 12'(m_best), 3'(m_state)};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL model cyc=%0d: got %h expected %h", cyc, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
    start = 1'b0;
    btn   = 1'b0;
  endtask

  task automatic run_round(input vec_t v);
    int k, j, d, m, eb;
    bit saw;
    start = 1'b1;
    btn   = 1'b1;
    step();
    d = m_D;
    chk({v.name, "_clr"}, int'({foul, timeout}), 0);
    chk({v.name, "_busy"}, int'(busy), 1);
    saw = 0;
    if (v.kind == 0 || v.kind == 3) begin
      m = (v.kind == 0) ? v.off : 10 * d;
      for (int i = 1; i < m; i++) begin
        step();
        saw |= stim;
      end
      btn = 1'b1;
      step();
      saw |= stim;
      chk({v.name, "_nostim"}, int'(saw), 0);
    end else begin
      k = 1;
      while (!stim && k < 200) begin
        if (v.bstart && k == 3) start = 1'b1;
        step();
        k++;
      end
      chk({v.name, "_lat"}, k, 10 * d + 1);
      if (v.kind == 1) begin
        for (int i = 0; i < v.off; i++) begin
          if (v.bstart && i == 2) start = 1'b1;
          step();
        end
        btn = 1'b1;
        step();
      end else begin
        j = 0;
        while (!done && j < 260) begin
          step();
          j++;
        end
        chk({v.name, "_at"}, j, 200);
      end
    end
`ifdef BEST_TIME_EN
    eb = v.best;
`else
    eb = 4095;
`endif
    chk({v.name, "_done"}, int'(done), 1);
    chk({v.name, "_stim"}, int'(stim), 0);
    chk({v.name, "_react"}, int'(react_ms), v.react);
    chk({v.name, "_foul"}, int'(foul), int'(v.foul));
    chk({v.name, "_tmo"}, int'(timeout), int'(v.tmo));
    chk({v.name, "_state"}, int'(state), v.st);
    chk({v.name, "_best"}, int'(best_ms), eb);
    step();
    chk({v.name, "_done1"}, int'(done), 0);
  endtask

  initial begin
    bit saw;
    int k;
    tv[0] = '{1, 35, 0, 3, 0, 0, 3, 3, "valid"};
    tv[1] = '{0, 15, 0, 0, 1, 0, 4, 3, "foul"};
    tv[2] = '{2, 0, 0, 20, 0, 1, 3, 3, "timeout"};
    tv[3] = '{1, 199, 0, 20, 0, 0, 3, 3, "btn_tmo"};
    tv[4] = '{1, 55, 1, 5, 0, 0, 3, 3, "busy_start"};
    tv[5] = '{3, 0, 0, 0, 1, 0, 4, 3, "foul_last"};
    tv[6] = '{1, 0, 0, 0, 0, 0, 3, 0, "zero"};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_state", int'(state), 0);
    chk("rst_best", int'(best_ms), 4095);
    chk("rst_outs", int'({stim, busy, done, foul, timeout}), 0);
    chk("rst_react", int'(react_ms), 0);
    rst_n = 1'b1;

    saw = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      saw |= stim;
    end
    chk("idle_nostim", int'(saw), 0);

    foreach (tv[i]) run_round(tv[i]);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      btn   = ($urandom_range(0, 69) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_n = 1'b1;

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    k = 0;
    while (!stim && k < 200) begin
      step();
      k++;
    end
    chk("mid_reach", int'(stim), 1);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    chk("mid_stim", int'(stim), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_best", int'(best_ms), 4095);
    chk("mid_state", int'(state), 0);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      saw |= done;
    end
    chk("mid_nodone", int'(saw), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
